vga_timing_encoder: RTL
=======================

VGA_TIMING_ENCODER -- requirements
Module: vga_timing_encoder

Interface
REQ-001 The block SHALL expose parameter H_VISIBLE, default 640: active pixels per line.
REQ-002 The block SHALL expose parameter V_VISIBLE, default 480: active lines per frame.
REQ-003 The block SHALL take all other horizontal and vertical timings (H_FRONT 16, H_SYNC 96, H_BACK 48, H_TOTAL 800, V_FRONT 10, V_SYNC 2, V_BACK 33, V_TOTAL 525) from the shared package, not from parameters.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port: clk  input  1  system clock, all state on its rising edge.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: ena  input  1  global enable; 0 freezes all state.
REQ-008 Port: rgb_in  input  6  pixel colour {R[1:0],G[1:0],B[1:0]} for the current x_out/y_out.
REQ-009 Port: x_out  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-010 Port: y_out  output  10  current vertical count, 0..V_TOTAL-1.
REQ-011 Port: visible  output  1  high when x_out<H_VISIBLE and y_out<V_VISIBLE.
REQ-012 Port: pix_tick  output  1  one-clk strobe marking a pixel advance.
REQ-013 Port: frame_start  output  1  high for the pix_tick cycle where x_out=0 and y_out=0.
REQ-014 Port: uo_out  output  8  packed VGA: [7]=HS,[6]=B0,[5]=G0,[4]=R0,[3]=VS,[2]=B1,[1]=G1,[0]=R1.

Function
REQ-015 The counters x_out and y_out SHALL advance only on cycles with pix_tick=1 and ena=1.
REQ-016 When x_out=H_TOTAL-1 on a tick, x_out SHALL wrap to 0 and y_out SHALL increment, wrapping from V_TOTAL-1 to 0.
REQ-017 Raw HS SHALL be 0 (active low) iff H_VISIBLE+H_FRONT <= x_out < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
REQ-018 Raw VS SHALL be 0 (active low) iff V_VISIBLE+V_FRONT <= y_out < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
REQ-019 uo_out SHALL be a register loaded on each tick from raw HS/VS and rgb_in at the pre-tick x_out/y_out, so it lags coordinates by exactly one pixel.
REQ-020 The colour bits loaded into uo_out SHALL be forced to 0 when visible=0, regardless of rgb_in.
REQ-021 rgb_in SHALL be sampled only on tick cycles; its value on non-tick cycles SHALL be ignored.
REQ-022 When ena=0, the divider, counters and uo_out SHALL hold, and pix_tick SHALL read 0.
REQ-023 visible and frame_start SHALL be combinational decodes of the current counters (frame_start additionally gated by pix_tick).

Reset
REQ-024 On rst_n=0, x_out, y_out and the divider SHALL clear immediately, independent of clk.
REQ-025 On rst_n=0, uo_out SHALL be 8'b1000_1000 (syncs inactive, colour black).
REQ-026 The first tick after rst_n deasserts SHALL load uo_out for pixel (0,0); reset mid-frame SHALL restart at (0,0) with no partial-line carry-over.

Configuration
REQ-027 Macro VGA_CLKDIV2_EN defined: pix_tick SHALL assert on alternate enabled clk cycles (50 MHz clk -> 25 MHz pixel), the first being the second enabled cycle after reset.
REQ-028 Macro VGA_CLKDIV2_EN undefined: pix_tick SHALL equal ena every cycle (clk is the 25 MHz pixel clock) and no divider flop SHALL exist.

Structure
REQ-029 Package vga_timing_pkg SHALL hold all H_/V_ timing constants, the uo_out bit-index constants and the rgb_in field typedef.
REQ-030 One sub-module, vga_axis_counter (wrapping counter with terminal-count output), SHALL be instantiated twice, once for horizontal and once for vertical.

Verification
REQ-031 Reset test: hold rst_n=0 -> uo_out=8'h88, x_out=0, y_out=0; deassert rst_n -> first tick with x_out=0, y_out=0 gives frame_start=1.
REQ-032 HS width test: count ticks with uo_out[7]=0 per line -> exactly 96, first low tick at pre-tick x_out=656, line period 800 ticks.
REQ-033 VS width test: count lines with uo_out[3]=0 -> exactly 2 lines (y=490,491), frame period 420000 ticks.
REQ-034 Blanking test: rgb_in=6'b111111 constant -> uo_out=8'hFF at pixel (0,0) and (639,479), uo_out=8'h88 at (640,0), uo_out=8'h08 at (700,0) during HS.
REQ-035 Enable test: drop ena for 10 clks at x_out=100 -> x_out stays 100, uo_out unchanged; after ena returns, next tick gives x_out=101.
REQ-036 Divider test: with VGA_CLKDIV2_EN, 1600 enabled clks -> one full line; without it, 800 clks -> one full line.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, uo_out bit map and colour field type.
// Shared by vga_axis_counter and vga_timing_encoder.
package vga_timing_pkg;

  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_TOTAL = 800;

  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_TOTAL = 525;

  localparam int CNT_W = 10;

  localparam int UO_HS = 7;
  localparam int UO_B0 = 6;
  localparam int UO_G0 = 5;
  localparam int UO_R0 = 4;
  localparam int UO_VS = 3;
  localparam int UO_B1 = 2;
  localparam int UO_G1 = 1;
  localparam int UO_R1 = 0;

  localparam logic [7:0] UO_RESET = 8'h88;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 counter advancing on inc, with terminal-count flag.
// Used once per screen axis by vga_timing_encoder.
module vga_axis_counter #(
  parameter int TOTAL = 800,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  assign last = (count == LAST);

  // Advance on inc, wrapping to zero after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_encoder.sv
// VGA timing generator with registered packed sync/colour output.
// Define VGA_CLKDIV2_EN to derive the pixel tick from clk/2.
module vga_timing_encoder
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [5:0] rgb_in,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       visible,
  output logic       pix_tick,
  output logic       frame_start,
  output logic [7:0] uo_out
);

  localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_LO = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       tick;
  logic       x_last;
  logic       unused_y_last;
  logic       hs_raw;
  logic       vs_raw;
  rgb_t       rgb;
  logic [7:0] uo_next;

`ifdef VGA_CLKDIV2_EN
  logic div;

  // Toggle phase on enabled clks; tick on every second one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= 1'b0;
    end else if (ena) begin
      div <= ~div;
    end
  end

  assign tick = ena & div;
`else
  assign tick = ena;
`endif

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .W     (CNT_W)
  ) u_h (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tick),
    .count (x_out),
    .last  (x_last)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .W     (CNT_W)
  ) u_v (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tick & x_last),
    .count (y_out),
    .last  (unused_y_last)
  );

  assign pix_tick    = tick;
  assign visible     = (x_out < H_VIS) && (y_out < V_VIS);
  assign frame_start = tick && (x_out == '0) && (y_out == '0);
  assign hs_raw      = !((x_out >= HS_LO) && (x_out < HS_HI));
  assign vs_raw      = !((y_out >= VS_LO) && (y_out < VS_HI));

  // Pack syncs and blank-masked colour for the current pixel.
  always_comb begin
    uo_next        = '0;
    rgb            = visible ? rgb_t'(rgb_in) : '0;
    uo_next[UO_HS] = hs_raw;
    uo_next[UO_VS] = vs_raw;
    uo_next[UO_R1] = rgb.r[1];
    uo_next[UO_R0] = rgb.r[0];
    uo_next[UO_G1] = rgb.g[1];
    uo_next[UO_G0] = rgb.g[0];
    uo_next[UO_B1] = rgb.b[1];
    uo_next[UO_B0] = rgb.b[0];
  end

  // Output register, one pixel behind the coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_out <= UO_RESET;
    end else if (tick) begin
      uo_out <= uo_next;
    end
  end

endmodule
